// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and keeps one request in flight to a variable-latency instruction
// memory. It follows the hazard unit's PCWrite/IF_ID_Write stalls and redirects
// on branches resolved in ID. A one-entry hold buffer keeps a word that returns
// during a stall, and two saturating counters track stall and bubble cycles.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             PCWrite,
   input  logic             IF_ID_Write,
   input  logic             BranchTaken_ID,
   input  logic [31:0]      BranchTarget_ID,
   output logic             IMemReq,
   output logic [31:0]      IMemAddr,
   input  logic             IMemReady,
   input  logic [31:0]      IMemData,
   output logic [31:0]      Instruction_ID,
   output logic [31:0]      PCPlus4_ID,
   output logic             Valid_ID,
   output logic [31:0]      PC_IF,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] BubbleCycles
);

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic             imem_req_q, imem_req_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc4_id_q, pc4_id_d;
   logic             valid_q, valid_d;
   logic [31:0]      hold_buf_q, hold_buf_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   logic             redirect;
   logic             bubble;
   logic [31:0]      pc_plus4;

   // The low target bits are forced to zero, so they are deliberately unused.
   logic             unused_target_lsbs;
   assign unused_target_lsbs = ^BranchTarget_ID[1:0];

   // Next-state logic: a redirect wins over everything; otherwise FETCH/HOLD handling.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc4_id_d     = pc4_id_q;
      valid_d      = valid_q;
      hold_buf_d   = hold_buf_q;
      bubble       = 1'b0;
      redirect     = IF_ID_Write & BranchTaken_ID;
      pc_plus4     = pc_q + 32'd4;

      if (redirect) begin
         pc_d       = {BranchTarget_ID[31:2], 2'b00};
         instr_d    = 32'h0;
         valid_d    = 1'b0;
         hold_buf_d = 32'h0;
         bubble     = 1'b1;
         state_d    = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (IMemReady) begin
                  if (IF_ID_Write) begin
                     instr_d  = IMemData;
                     pc4_id_d = pc_plus4;
                     valid_d  = 1'b1;
                     if (PCWrite) begin
                        pc_d = pc_plus4;
                     end
                  end else begin
                     hold_buf_d = IMemData;
                     state_d    = HOLD;
                  end
               end else if (IF_ID_Write) begin
                  instr_d = 32'h0;
                  valid_d = 1'b0;
                  bubble  = 1'b1;
               end
            end
            HOLD: begin
               if (IF_ID_Write) begin
                  instr_d  = hold_buf_q;
                  pc4_id_d = pc_plus4;
                  valid_d  = 1'b1;
                  if (PCWrite) begin
                     pc_d = pc_plus4;
                  end
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end

      imem_req_d = (state_d == FETCH);

      stall_cnt_d = stall_cnt_q;
      if (!IF_ID_Write && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end

      bubble_cnt_d = bubble_cnt_q;
      if (bubble && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
   end

   // State, PC, IF/ID register, hold buffer and counters, all cleared asynchronously.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q      <= FETCH;
         imem_req_q   <= 1'b1;
         pc_q         <= RESET_PC;
         instr_q      <= 32'h0;
         pc4_id_q     <= 32'h0;
         valid_q      <= 1'b0;
         hold_buf_q   <= 32'h0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         imem_req_q   <= imem_req_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pc4_id_q     <= pc4_id_d;
         valid_q      <= valid_d;
         hold_buf_q   <= hold_buf_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign IMemReq        = imem_req_q;
   assign IMemAddr       = pc_q;
   assign PC_IF          = pc_q;
   assign Instruction_ID = instr_q;
   assign PCPlus4_ID     = pc4_id_q;
   assign Valid_ID       = valid_q;
   assign StallCycles    = stall_cnt_q;
   assign BubbleCycles   = bubble_cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with its IF/ID pipeline register, directly upstream of the hazard detection unit and ID stage.
- Owns the PC and issues one request at a time to a variable-latency instruction memory.
- Obeys the PCWrite/IF_ID_Write stall outputs of the hazard detection unit and redirects on branches resolved in ID.
- Holds a one-entry buffer so an instruction returned during a stall is not lost; keeps stall and bubble counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the saturating performance counters

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  reset, asynchronous, active-low
PCWrite  input  1  from hazard detection unit; 0 = PC must not advance
IF_ID_Write  input  1  from hazard detection unit; 0 = IF/ID register must hold
BranchTaken_ID  input  1  branch/jump resolved taken in ID this cycle
BranchTarget_ID  input  32  redirect address
IMemReq  output  1  instruction memory request valid
IMemAddr  output  32  word-aligned fetch address
IMemReady  input  1  memory returns IMemData for the current IMemAddr this cycle
IMemData  input  32  instruction word
Instruction_ID  output  32  IF/ID instruction (opcode in [31:26] feeds hazard unit)
PCPlus4_ID  output  32  IF/ID PC+4
Valid_ID  output  1  IF/ID holds a real instruction
PC_IF  output  32  current PC
StallCycles  output  CNT_W  cycles with IF_ID_Write=0
BubbleCycles  output  CNT_W  bubbles inserted due to memory wait or redirect

Behaviour:
- Reset (Rst=0, asynchronous): PC_IF=RESET_PC; Instruction_ID=0 (NOP); PCPlus4_ID=0; Valid_ID=0; hold buffer empty; counters=0; state=FETCH. First IMemReq is the first cycle after release.
- States: FETCH, HOLD.
- FETCH: IMemReq=1, IMemAddr=PC_IF. A request completes only in a cycle with IMemReq=1 and IMemReady=1. IMemAddr may change before completion (redirect); memory then serves the new address.
- FETCH, IMemReady=1, IF_ID_Write=1, no redirect: Instruction_ID<=IMemData; PCPlus4_ID<=PC_IF+4; Valid_ID<=1. If PCWrite=1, PC_IF<=PC_IF+4.
- FETCH, IMemReady=1, IF_ID_Write=0: IMemData goes to the hold buffer; IF/ID unchanged; PC unchanged; next state HOLD.
- FETCH, IMemReady=0, IF_ID_Write=1: bubble. Instruction_ID<=0, Valid_ID<=0, BubbleCycles+1.
- FETCH, IMemReady=0, IF_ID_Write=0: IF/ID holds.
- HOLD: IMemReq=0. While IF_ID_Write=0, everything holds. First cycle with IF_ID_Write=1: buffer to IF/ID (Valid_ID<=1, PCPlus4_ID<=PC_IF+4); PC_IF<=PC_IF+4 if PCWrite=1; next state FETCH.
- Redirect: BranchTaken_ID is honoured only when IF_ID_Write=1; it is ignored while stalled. When honoured it has top priority, in any state:
  - PC_IF<={BranchTarget_ID[31:2],2'b00};
  - IF/ID flushed (Instruction_ID<=0, Valid_ID<=0, BubbleCycles+1);
  - same-cycle IMemData dropped; hold buffer discarded;
  - next state FETCH.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- PCWrite=1 with IF_ID_Write=0 is treated as PCWrite=0 (no PC advance without an IF/ID load).
- Counters saturate at all-ones and never wrap.
- StallCycles increments every cycle with IF_ID_Write=0, including the cycle reset is released.
- Reset mid-request or in HOLD: immediate return to reset values; the outstanding request is abandoned.

Test Plan:
- Reset release, IMemReady always 1, IMemData=addr-derived, stalls off -> IMemAddr 0,4,8,...; Instruction_ID follows one cycle later; Valid_ID=1 from cycle 2; BubbleCycles=0.
- IMemReady=0 for 3 cycles on address 0x8 -> Valid_ID=0 for 3 cycles, Instruction_ID=0, BubbleCycles=3, PC_IF stays 0x8; then the 0x8 word loads with PCPlus4_ID=0xC.
- IF_ID_Write=PCWrite=0 for 2 cycles while IMemReady=1 -> state HOLD, IMemReq=0, IF/ID unchanged, StallCycles=2; on release the buffered word enters IF/ID and PC advances once.
- BranchTaken_ID=1, target 0x0000_0103, IF_ID_Write=1 during a memory wait -> PC_IF=0x100, Valid_ID=0, next IMemAddr=0x100, stale response not loaded.
- BranchTaken_ID=1 with IF_ID_Write=0 -> ignored, PC unchanged; the same branch is taken the cycle IF_ID_Write returns to 1.
- Rst asserted in HOLD mid-cycle -> outputs return to reset values asynchronously; PC=RESET_PC; counters cleared.
